// File: rtl/seg_scan_display_if.sv
// rtl/seg_scan_display_if.sv - display-side signal bundle for seg_scan_display
//
// Purpose: groups the BCD/brightness request inputs and the multiplexed
// display outputs of seg_scan_display into one interface.
//
// Parameters:
//   NUM_DIGITS  number of scanned digits (1..8)
//   BRIGHT_W    brightness select width
//
// Signals:
//   digits_in   [4*NUM_DIGITS-1:0]  BCD nibbles, digit 0 in bits [3:0]
//   dp_in       [NUM_DIGITS-1:0]    decimal point request, 1 = lit
//   brightness  [BRIGHT_W-1:0]      on-duty select, all-ones = full
//   enable                          0 blanks the whole display
//   ss_out      [6:0]               segments {a..g}, active-low
//   dp_out                          decimal point segment, active-low
//   en_out      [NUM_DIGITS-1:0]    digit anodes, active-low
//   frame_tick                      one-cycle pulse at scan wrap
//
// Modports: master = upstream score/timer logic, slave = the scanner.

interface seg_scan_display_if #(
    parameter int NUM_DIGITS = 4,
    parameter int BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [BRIGHT_W-1:0]     brightness;
    logic                    enable;
    logic [6:0]              ss_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   en_out;
    logic                    frame_tick;

    modport master (
        output digits_in, dp_in, brightness, enable,
        input  ss_out, dp_out, en_out, frame_tick
    );

    modport slave (
        input  digits_in, dp_in, brightness, enable,
        output ss_out, dp_out, en_out, frame_tick
    );
endinterface

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed N-digit seven-segment scanner with PWM
//
// Purpose: scans NUM_DIGITS BCD digits onto common-anode display pins.
// Each digit slot is 2^BRIGHT_W brightness steps of STEP_DIV clocks; a digit
// is driven only while the step counter is <= the brightness select. Inputs
// are snapshotted once per frame (on the wrap back to digit 0) so a value
// change mid-frame never shows mixed digits.
//
// Optional feature: define SEG_LZ_BLANK_EN to enable leading-zero blanking
// of the snapshotted digits (digit 0 is never blanked).
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   seg_scan_display_if.slave
//           in : digits_in, dp_in, brightness, enable
//           out: ss_out, dp_out, en_out, frame_tick (all registered)

module seg_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int STEP_DIV   = 3125,
    parameter int BRIGHT_W   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seg_scan_display_if.slave    bus
);

    localparam int PRE_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PRE_W-1:0]        pre;
    logic [BRIGHT_W-1:0]     step;
    logic [IDX_W-1:0]        idx;

    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic [BRIGHT_W-1:0]     sh_bright;

    logic                    step_stb;
    logic                    slot_end;
    logic                    last_idx;
    logic                    frame_wrap;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    digit_on;
    logic [6:0]              ss_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   en_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = 7'b0000001;
            4'd1:    seg_decode = 7'b1001111;
            4'd2:    seg_decode = 7'b0010010;
            4'd3:    seg_decode = 7'b0000110;
            4'd4:    seg_decode = 7'b1001100;
            4'd5:    seg_decode = 7'b0100100;
            4'd6:    seg_decode = 7'b0100000;
            4'd7:    seg_decode = 7'b0001111;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0001100;
            default: seg_decode = 7'b1111110;   // non-BCD shows a dash
        endcase
    endfunction

    // The slot end is a step strobe on the last step, so a coincident step
    // wrap and slot end is a single event by construction.
    assign step_stb   = (pre == PRE_W'(STEP_DIV - 1));
    assign slot_end   = step_stb && (step == {BRIGHT_W{1'b1}});
    assign last_idx   = (idx == IDX_W'(NUM_DIGITS - 1));
    assign frame_wrap = slot_end && last_idx;

`ifdef SEG_LZ_BLANK_EN
    logic higher_blank;

    // A digit is blanked when it is zero and every digit above it is blanked.
    always_comb begin
        lz_blank     = '0;
        higher_blank = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            if (higher_blank && (sh_digits[4*k +: 4] == 4'd0)) begin
                lz_blank[k] = 1'b1;
            end else begin
                higher_blank = 1'b0;
            end
        end
    end
`else
    assign lz_blank = '0;
`endif

    always_comb begin
        cur_nib  = sh_digits[idx*4 +: 4];
        digit_on = bus.enable && (step <= sh_bright) && !lz_blank[idx];
        if (digit_on) begin
            en_next = ~(NUM_DIGITS'(1) << idx);
            ss_next = seg_decode(cur_nib);
            dp_next = ~sh_dp[idx];
        end else begin
            en_next = {NUM_DIGITS{1'b1}};
            ss_next = 7'b1111111;
            dp_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre            <= '0;
            step           <= '0;
            idx            <= '0;
            sh_digits      <= '0;
            sh_dp          <= '0;
            sh_bright      <= '0;
            bus.ss_out     <= 7'b1111111;
            bus.dp_out     <= 1'b1;
            bus.en_out     <= {NUM_DIGITS{1'b1}};
            bus.frame_tick <= 1'b0;
        end else begin
            if (step_stb) begin
                pre  <= '0;
                step <= step + 1'b1;    // natural wrap at 2^BRIGHT_W
            end else begin
                pre  <= pre + 1'b1;
            end

            if (slot_end) begin
                idx <= last_idx ? '0 : idx + 1'b1;
            end

            // Snapshot only at the wrap to digit 0 so a frame is tear-free.
            if (frame_wrap) begin
                sh_digits <= bus.digits_in;
                sh_dp     <= bus.dp_in;
                sh_bright <= bus.brightness;
            end

            bus.frame_tick <= frame_wrap;
            bus.en_out     <= en_next;
            bus.ss_out     <= ss_next;
            bus.dp_out     <= dp_next;
        end
    end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
Parametrised time-multiplexed seven-segment driver for N BCD digits, the successor to the fixed 3-digit scanner. Adds:
- a digit count set by parameter
- a PWM brightness control
- per-digit decimal points
- tear-free frame snapshotting
- a frame-boundary strobe
It sits between the score/timer BCD logic and the board's common-anode display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
STEP_DIV, 3125, clk cycles per brightness step
BRIGHT_W, 4, brightness width; 2^BRIGHT_W steps per digit slot (default slot = 50000 clk)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
digits_in  in  4*NUM_DIGITS  BCD nibbles, digit k = bits [4k+3:4k], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, 1 = lit
brightness  in  BRIGHT_W  on-duty select, 0 = dimmest, all-ones = full
enable  in  1  0 = blank whole display
ss_out  out  7  segments {a,b,c,d,e,f,g}, active-low
dp_out  out  1  decimal point segment, active-low
en_out  out  NUM_DIGITS  digit anodes, active-low, at most one low
frame_tick  out  1  one-cycle pulse when scan wraps to digit 0

Behaviour:
- Clock and reset: one clock domain. All outputs are registered.
- rst asserted, asynchronously including mid-operation:
  - ss_out=7'b1111111, dp_out=1, en_out all ones, frame_tick=0
  - prescaler, step counter and digit index = 0
  - shadow registers (digits, dp, brightness) = 0
- Prescaler: counts 0..STEP_DIV-1, then wraps; each wrap is a step strobe.
- Step counter: counts 0..2^BRIGHT_W-1 on step strobes. Its wrap ends the digit slot.
- Digit index:
  - Advances on slot end: 0,1,…,NUM_DIGITS-1, then 0.
  - Wrap to 0 loads the shadow registers from digits_in, dp_in and brightness, and pulses frame_tick for exactly that cycle.
  - Inputs are otherwise ignored, so a value change mid-frame never shows mixed digits.
- Outputs, registered, one clk after the internal state:
  - Digit "on" when enable=1 AND step counter <= shadow brightness.
  - When on: en_out bit[idx]=0, all other bits 1; ss_out = decode(shadow nibble idx); dp_out = ~shadow dp[idx].
  - When off: en_out all ones, ss_out 7'b1111111, dp_out 1.
- Decode table, active-low:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
  - nibbles 10..15 = 1111110 (dash, g only)
- Duty: (brightness+1)/2^BRIGHT_W. Full scale = continuous on during the slot.
- enable: low blanks the outputs only. Counters and snapshotting continue, so frame_tick keeps running.
- NUM_DIGITS=1: the index stays 0, and frame_tick pulses every slot.
- Simultaneous events: a step strobe and a slot end in the same cycle are one event. Counters wrap together, and the index advances once.

Optional Feature:
Macro SEG_LZ_BLANK_EN.
- Defined: leading-zero blanking, computed on the shadow digits. Scanning from the most significant digit downward, each digit whose nibble is 0 and whose higher digits are all blank is forced off (en_out all ones, dp_out 1 for that slot). Digit 0 is never blanked. A lit dp does not stop blanking.
- Undefined: every digit is displayed, zeros included.

Test Plan:
1. Reset and load: NUM_DIGITS=4, STEP_DIV=2, BRIGHT_W=2, brightness=3, enable=1, digits_in=16'h0000. Release rst.
   -> en_out cycles 1110,1101,1011,0111, 8 clk each; ss_out=0000001.
   -> frame_tick pulses every 32 clk.
2. Snapshot: digits_in=16'h1234. Change to 16'h5678 mid-frame.
   -> Remainder of the frame still shows 4,3,2,1 (1001100, 0000110, 0010010, 1001111).
   -> 5678 appears only after the next frame_tick.
3. Brightness: brightness=0.
   -> Each digit's en_out bit is low for 2 clk of its 8-clk slot.
   -> brightness=1 gives 4 clk; brightness=3 gives 8 clk.
4. Enable and decimal point: enable=0 -> en_out=1111 and ss_out=1111111 continuously, while frame_tick continues. dp_in=4'b0100, enable=1 -> dp_out=0 only while en_out=1011.
5. Invalid digit: digits_in=16'h00A7 -> digit 1 shows 1111110 and digit 0 shows 0001111. With SEG_LZ_BLANK_EN, digits_in=16'h0070 -> digits 3 and 2 are never enabled, digit 1 shows 0001111, digit 0 shows 0000001.
6. Async reset mid-slot: assert rst between clock edges. -> en_out=1111 immediately, without waiting for a clock edge. After release, scanning restarts at digit 0 showing 0.
